uart_frame_decoder: RTL and testbench

Parametrised successor to the fixed-length UART packet decoder. It assembles framed byte streams from the UART receiver into pattern and control words for the differential-frequency serial-out channels. Frames start with a sync byte, carry a channel index, and end with an XOR checksum. A per-byte inter-byte timeout resynchronises the decoder on a broken stream. Decoded fields are registered and held until the next good frame; malformed frames are dropped and reported with an error code.

---
 rtl/uart_frame_decoder.sv | 127 ++++++++++++
 tb/tb_uart_frame_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: assembles SYNC/CTRL/FREQ/OUT/CSUM byte frames into registered pattern and control words.
module uart_frame_decoder #(
    parameter int         DATA_BIT    = 32,
    parameter int         CH_NUM      = 16,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          i_data,
    input  logic                i_rx_done_tick,
    output logic [DATA_BIT-1:0] o_output_pattern,
    output logic [DATA_BIT-1:0] o_freq_pattern,
    output logic [3:0]          o_sel_out,
    output logic                o_start,
    output logic                o_stop,
    output logic                o_mode,
    output logic                o_done_tick,
    output logic                o_err_tick,
    output logic [1:0]          o_err_code
);
    localparam int NB = DATA_BIT / 8;
    localparam int CW = $clog2(NB) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {S_SYNC, S_CTRL, S_FREQ, S_OUT, S_CSUM} state_t;

    state_t              state, state_nx;
    logic [CW-1:0]       bcnt;
    logic [TW-1:0]       tcnt;
    logic [DATA_BIT-1:0] freq_buf, out_buf;
    logic [3:0]          sel_buf;
    logic [2:0]          bits_buf;
    logic [7:0]          xor_acc;
    logic                commit, err, tmo, last;
    logic [1:0]          code;

    assign last = bcnt == CW'(NB - 1);
    // fires one cycle early so the registered error lands TIMEOUT_CYC cycles after the last tick
    assign tmo  = state != S_SYNC && !i_rx_done_tick && tcnt == TW'(TIMEOUT_CYC - 2);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_SYNC;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        err      = 1'b0;
        code     = 2'd0;
        if (tmo) begin
            state_nx = S_SYNC;
            err      = 1'b1;
            code     = 2'd3;
        end else if (i_rx_done_tick) begin
            case (state)
                S_SYNC:  state_nx = i_data == SYNC_BYTE ? S_CTRL : S_SYNC;
                S_CTRL:  state_nx = S_FREQ;
                S_FREQ:  state_nx = last ? S_OUT : S_FREQ;
                S_OUT:   state_nx = last ? S_CSUM : S_OUT;
                default: begin
                    state_nx = S_SYNC;
                    code     = i_data != xor_acc ? 2'd1 : {1'b0, sel_buf} >= 5'(CH_NUM) ? 2'd2 : 2'd0;
                    err      = code != 2'd0;
                    commit   = code == 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_output_pattern <= '0;
            o_freq_pattern   <= '0;
            o_sel_out        <= '0;
            o_start          <= 1'b0;
            o_stop           <= 1'b0;
            o_mode           <= 1'b0;
            o_done_tick      <= 1'b0;
            o_err_tick       <= 1'b0;
            o_err_code       <= '0;
            freq_buf         <= '0;
            out_buf          <= '0;
            sel_buf          <= '0;
            bits_buf         <= '0;
            xor_acc          <= '0;
            bcnt             <= '0;
            tcnt             <= '0;
        end else begin
            o_done_tick <= commit;
            o_err_tick  <= err;
            if (err) o_err_code <= code;
            if (commit) begin
                o_freq_pattern   <= freq_buf;
                o_output_pattern <= out_buf;
                o_sel_out        <= sel_buf;
                o_start          <= bits_buf[0];
                o_stop           <= bits_buf[1];
                o_mode           <= bits_buf[2];
            end
            tcnt <= i_rx_done_tick || state == S_SYNC ? '0 : tcnt + TW'(1);
            bcnt <= state_nx != state ? '0 : bcnt + CW'(i_rx_done_tick);
            if (tmo) begin
                freq_buf <= '0;
                out_buf  <= '0;
                sel_buf  <= '0;
                bits_buf <= '0;
                xor_acc  <= '0;
            end else if (i_rx_done_tick) begin
                if (state == S_CTRL) begin
                    sel_buf  <= i_data[7:4];
                    bits_buf <= i_data[2:0];
                    xor_acc  <= i_data;
                end
                // bytes arrive LSB first, so each new byte enters at the top and slides down
                if (state == S_FREQ) begin
                    freq_buf <= DATA_BIT'({i_data, freq_buf} >> 8);
                    xor_acc  <= xor_acc ^ i_data;
                end
                if (state == S_OUT) begin
                    out_buf <= DATA_BIT'({i_data, out_buf} >> 8);
                    xor_acc <= xor_acc ^ i_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb_uart_frame_decoder: random and directed frames checked against a byte-queue reference model.
module tb_uart_frame_decoder;
    localparam int         DB   = 32;
    localparam int         NB   = DB / 8;
    localparam int         CHN  = 8;
    localparam int         TO   = 50;
    localparam logic [7:0] SYNC = 8'hA5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    i_data = 8'h00;
    logic          i_rx_done_tick = 1'b0;
    logic [DB-1:0] o_output_pattern, o_freq_pattern;
    logic [3:0]    o_sel_out;
    logic          o_start, o_stop, o_mode, o_done_tick, o_err_tick;
    logic [1:0]    o_err_code;

    int total = 0;
    int bad = 0;

    uart_frame_decoder #(.DATA_BIT(DB), .CH_NUM(CHN), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_rx_done_tick(i_rx_done_tick),
        .o_output_pattern(o_output_pattern), .o_freq_pattern(o_freq_pattern), .o_sel_out(o_sel_out),
        .o_start(o_start), .o_stop(o_stop), .o_mode(o_mode), .o_done_tick(o_done_tick),
        .o_err_tick(o_err_tick), .o_err_code(o_err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a frame is the list of bytes after SYNC; it is judged once 2*NB+2 bytes are in.
    logic [DB-1:0] exp_freq = '0, exp_out = '0;
    logic [3:0]    exp_sel = '0;
    logic          exp_start = 0, exp_stop = 0, exp_mode = 0, exp_done = 0, exp_err = 0;
    logic [1:0]    exp_code = '0;
    logic [7:0]    q[$];
    bit            in_frame = 0;
    longint        cyc = 0, last_t = 0;

    always @(posedge clk) begin
        logic [7:0]    x, c;
        logic [DB-1:0] f, o;
        if (!rst_n) begin
            {exp_freq, exp_out, exp_sel, exp_start, exp_stop, exp_mode} = '0;
            {exp_done, exp_err, exp_code} = '0;
            in_frame = 0;
            q.delete();
        end else begin
            exp_done = 0;
            exp_err  = 0;
            if (i_rx_done_tick) begin
                last_t = cyc;
                if (!in_frame) begin
                    if (i_data == SYNC) begin
                        in_frame = 1;
                        q.delete();
                    end
                end else begin
                    q.push_back(i_data);
                    if (q.size() == 2 * NB + 2) begin
                        x = 0;
                        for (int i = 0; i <= 2 * NB; i++) x ^= q[i];
                        c = q[0];
                        if (q[2*NB+1] != x) begin
                            exp_err = 1; exp_code = 1;
                        end else if (int'(c[7:4]) >= CHN) begin
                            exp_err = 1; exp_code = 2;
                        end else begin
                            f = '0; o = '0;
                            for (int i = 0; i < NB; i++) begin
                                f |= DB'(q[1+i]) << (8 * i);
                                o |= DB'(q[1+NB+i]) << (8 * i);
                            end
                            exp_done = 1;
                            exp_freq = f; exp_out = o; exp_sel = c[7:4];
                            exp_start = c[0]; exp_stop = c[1]; exp_mode = c[2];
                        end
                        in_frame = 0;
                    end
                end
            end else if (in_frame && cyc - last_t == TO - 1) begin
                exp_err = 1; exp_code = 3; in_frame = 0;
            end
        end
        cyc++;
        #1;
        check("done_tick", o_done_tick, exp_done);
        check("err_tick", o_err_tick, exp_err);
        check("err_code", o_err_code, exp_code);
        check("freq", o_freq_pattern, exp_freq);
        check("out", o_output_pattern, exp_out);
        check("sel", o_sel_out, exp_sel);
        check("ctrl_bits", {o_start, o_stop, o_mode}, {exp_start, exp_stop, exp_mode});
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        i_data = b;
        i_rx_done_tick = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_rx_done_tick = 0;
        end
    endtask

    // Standard payload 78 56 34 12 EF BE AD DE back-to-back; returns in the cycle after the CSUM tick.
    task automatic send_std(input logic [7:0] ctrl, input logic [7:0] cs);
        logic [7:0] pl[8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send(SYNC);
        send(ctrl);
        foreach (pl[i]) send(pl[i]);
        send(cs);
        @(posedge clk);
        #1;
    endtask

    task automatic pick_gap(output int g);
        int r = $urandom_range(0, 19);
        g = r < 10 ? 0 : r < 16 ? $urandom_range(1, 3) : r == 16 ? TO - 2 : r == 17 ? TO - 1 : r == 18 ? TO + 3 : 1;
    endtask

    initial begin
        logic [7:0]  fr[$];
        logic [7:0]  ctrl, x;
        logic [31:0] f, o;
        int          g;
        idle(3);
        @(posedge clk); #1;
        check("reset_freq", o_freq_pattern, 0);
        check("reset_done", o_done_tick, 0);
        @(negedge clk) rst_n = 1;

        send_std(8'h35, 8'h1F);
        check("t1_done", o_done_tick, 1);
        check("t1_freq", o_freq_pattern, 32'h12345678);
        check("t1_out", o_output_pattern, 32'hDEADBEEF);
        check("t1_sel", o_sel_out, 3);
        check("t1_ssm", {o_start, o_stop, o_mode}, 3'b101);
        check("t1_model_freq", exp_freq, 32'h12345678);
        check("t1_model_out", exp_out, 32'hDEADBEEF);
        idle(2);

        send_std(8'h35, 8'h1E);
        check("t2_err", o_err_tick, 1);
        check("t2_code", o_err_code, 1);
        check("t2_done", o_done_tick, 0);
        check("t2_hold", o_freq_pattern, 32'h12345678);
        check("t2_model_code", exp_code, 1);
        idle(2);

        send_std(8'hF1, 8'hDB);
        check("t3_err", o_err_tick, 1);
        check("t3_code", o_err_code, 2);
        check("t3_hold_sel", o_sel_out, 3);
        idle(2);

        send(8'h00); idle(1); send(8'hFF); idle(1); send(8'h5A); idle(1);
        send_std(8'h12, 8'h38);
        check("t4_done", o_done_tick, 1);
        check("t4_sel", o_sel_out, 1);
        check("t4_ssm", {o_start, o_stop, o_mode}, 3'b010);
        idle(2);

        send(SYNC); send(8'h35); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        @(posedge clk); #1;
        i_rx_done_tick = 0;
        repeat (48) @(posedge clk);
        #1;
        check("t5_not_yet", o_err_tick, 0);
        @(posedge clk); #1;
        check("t5_err", o_err_tick, 1);
        check("t5_code", o_err_code, 3);
        idle(1);
        send_std(8'h35, 8'h1F);
        check("t5_recover", o_done_tick, 1);
        idle(2);

        send(SYNC); send(8'h47); send(8'h01);
        @(negedge clk);
        i_rx_done_tick = 0;
        rst_n = 0;
        @(posedge clk); #1;
        check("t6_freq", o_freq_pattern, 0);
        check("t6_sel", o_sel_out, 0);
        check("t6_code", o_err_code, 0);
        @(negedge clk) rst_n = 1;
        send_std(8'h35, 8'h1F);
        check("t6_done", o_done_tick, 1);
        check("t6_freq2", o_freq_pattern, 32'h12345678);
        idle(2);

        repeat (150) begin
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) begin send(8'($urandom)); idle(1); end
            ctrl = 8'($urandom);
            f = $urandom;
            o = $urandom;
            fr.delete();
            fr.push_back(ctrl);
            for (int i = 0; i < NB; i++) fr.push_back(f[8*i +: 8]);
            for (int i = 0; i < NB; i++) fr.push_back(o[8*i +: 8]);
            x = 0;
            foreach (fr[i]) x ^= fr[i];
            fr.push_back($urandom_range(0, 4) == 0 ? x ^ 8'(1 << $urandom_range(0, 7)) : x);
            send(SYNC);
            pick_gap(g);
            idle(g);
            foreach (fr[i]) begin
                send(fr[i]);
                pick_gap(g);
                idle(g);
            end
            idle($urandom_range(0, 2) == 0 ? 1 : 0);
        end
        idle(TO + 5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
